// File: rtl/conv3x3_prog.sv
// conv3x3_prog: programmable 3x3 convolution over CHANNELS planes.
// Shared signed kernel, shadow/active config committed at vsync rise.
module conv3x3_prog #(
    parameter int COLORDEPTH = 8,
    parameter int CHANNELS   = 3,
    parameter int COEFF_W    = 5
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CHANNELS-1:0][2:0][COLORDEPTH-1:0] vect_in,
    input  logic                                   dv_i,
    input  logic                                   hs_i,
    input  logic                                   vs_i,
    input  logic                                   cfg_we,
    input  logic [3:0]                             cfg_addr,
    input  logic [7:0]                             cfg_wdata,
    output logic [CHANNELS-1:0][COLORDEPTH-1:0]    pix_o,
    output logic                                   dv_o,
    output logic                                   hs_o,
    output logic                                   vs_o,
    output logic                                   line_end_o
);

    localparam int PW = COLORDEPTH + COEFF_W + 1;
    localparam int SW = COLORDEPTH + COEFF_W + 5;
    localparam logic signed [SW-1:0] MAXV = SW'((2 ** COLORDEPTH) - 1);

    function automatic logic signed [COEFF_W-1:0] dflt(input int k);
        if (k == 4) return COEFF_W'(4);
        if (k % 2 == 1) return COEFF_W'(2);
        return COEFF_W'(1);
    endfunction

    function automatic logic signed [PW-1:0] mul(
        input logic signed [COEFF_W-1:0] c,
        input logic [COLORDEPTH-1:0]     p
    );
        logic signed [PW-1:0] cs;
        logic signed [PW-1:0] ps;
        cs = PW'(c);
        ps = PW'(p);
        return cs * ps;
    endfunction

    function automatic logic [COLORDEPTH-1:0] sat(
        input logic signed [SW-1:0] s,
        input logic [3:0]           sh,
        input logic                 ab
    );
        logic signed [SW-1:0] v;
        v = s >>> sh;
        if (v < 0) v = ab ? -v : '0;
        if (v > MAXV) return '1;
        return v[COLORDEPTH-1:0];
    endfunction

    logic signed [COEFF_W-1:0] shd_coef [9];
    logic signed [COEFF_W-1:0] act_coef [9];
    logic [3:0]                shd_shift, act_shift;
    logic                      shd_abs, act_abs;
    logic                      dv_d, vs_d, commit, win_ok;
    logic [1:0]                col_cnt, row_cnt;
    logic [COLORDEPTH-1:0]     win [CHANNELS][3][3];
    logic [3:0]                v_p, hs_p, vs_p;
    logic signed [PW-1:0]      prod [CHANNELS][9];
    logic signed [SW-1:0]      sum_c [CHANNELS];
    logic signed [SW-1:0]      sum_q [CHANNELS];
    logic [3:0]                shift2, shift3;
    logic                      abs2, abs3;
    logic                      cfg_unused;

    assign commit     = vs_i & ~vs_d;
    assign win_ok     = dv_i & (col_cnt == 2'd2) & (row_cnt == 2'd2);
    assign dv_o       = v_p[3];
    assign hs_o       = hs_p[3];
    assign vs_o       = vs_p[3];
    assign cfg_unused = ^cfg_wdata[7:COEFF_W];

    // Shadow bank takes writes; active bank copies the old shadow on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                shd_coef[k] <= dflt(k);
                act_coef[k] <= dflt(k);
            end
            shd_shift <= 4'd4;
            act_shift <= 4'd4;
            shd_abs   <= 1'b0;
            act_abs   <= 1'b0;
        end else begin
            if (commit) begin
                for (int k = 0; k < 9; k++) act_coef[k] <= shd_coef[k];
                act_shift <= shd_shift;
                act_abs   <= shd_abs;
            end
            if (cfg_we) begin
                for (int k = 0; k < 9; k++)
                    if (cfg_addr == 4'(k)) shd_coef[k] <= cfg_wdata[COEFF_W-1:0];
                if (cfg_addr == 4'd9)  shd_shift <= cfg_wdata[3:0];
                if (cfg_addr == 4'd10) shd_abs   <= cfg_wdata[0];
            end
        end
    end

    // Border counters gate dv_o until the window holds real pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
            dv_d    <= 1'b0;
            vs_d    <= 1'b0;
        end else begin
            dv_d <= dv_i;
            vs_d <= vs_i;
            if (dv_i) begin
                if (col_cnt != 2'd2) col_cnt <= col_cnt + 2'd1;
            end else if (dv_d) begin
                col_cnt <= '0;
            end
            if (commit) row_cnt <= '0;
            else if (!dv_i && dv_d && row_cnt != 2'd2) row_cnt <= row_cnt + 2'd1;
        end
    end

    // Window shift: col2 <= col1 <= col0 <= incoming column.
    always_ff @(posedge clk) begin
        if (dv_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int r = 0; r < 3; r++) begin
                    win[c][2][r] <= win[c][1][r];
                    win[c][1][r] <= win[c][0][r];
                    win[c][0][r] <= vect_in[c][r];
                end
            end
        end
    end

    // Products use the active bank; shift/abs travel with them.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < 9; k++)
                prod[c][k] <= mul(act_coef[k], win[c][k % 3][k / 3]);
        shift2 <= act_shift;
        abs2   <= act_abs;
    end

    // Nine-term adder tree per channel.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sum_c[c] = '0;
            for (int k = 0; k < 9; k++) sum_c[c] = sum_c[c] + SW'(prod[c][k]);
        end
    end

    // Sum register.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) sum_q[c] <= sum_c[c];
        shift3 <= shift2;
        abs3   <= abs2;
    end

    // Valid/sync delay chain, normalise+saturate output, line end pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_p        <= '0;
            hs_p       <= '0;
            vs_p       <= '0;
            line_end_o <= 1'b0;
            pix_o      <= '0;
        end else begin
            v_p        <= {v_p[2:0], win_ok};
            hs_p       <= {hs_p[2:0], hs_i};
            vs_p       <= {vs_p[2:0], vs_i};
            line_end_o <= v_p[3] & ~v_p[2];
            if (v_p[2])
                for (int c = 0; c < CHANNELS; c++)
                    pix_o[c] <= sat(sum_q[c], shift3, abs3);
        end
    end

endmodule

// File: tb/tb_conv3x3_prog.sv
// tb_conv3x3_prog: random frames against a plain-arithmetic convolution
// model; expected pixels queued with their due cycle, monitor compares.
module tb_conv3x3_prog;
    localparam int CD = 8;
    localparam int CH = 3;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CH-1:0][2:0][CD-1:0] vect_in = '0;
    logic dv_i = 0, hs_i = 0, vs_i = 0, cfg_we = 0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic [CH-1:0][CD-1:0] pix_o;
    logic dv_o, hs_o, vs_o, line_end_o;

    conv3x3_prog #(.COLORDEPTH(CD), .CHANNELS(CH), .COEFF_W(CW)) dut (
        .clk(clk), .rst(rst), .vect_in(vect_in),
        .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .pix_o(pix_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .line_end_o(line_end_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int p[3]; } exp_t;
    typedef struct { int a; int d; } wr_t;

    int checks = 0, errors = 0;
    exp_t q[$];
    bit expdv[int];
    bit hsr[int];
    bit vsr[int];
    wr_t cfgq[$];
    wr_t midq[$];
    int last_rst = -1000;
    bit started = 0;
    int hold[3] = '{0, 0, 0};
    int img[3][12][20];

    int m_sc[9], m_ac[9];
    int m_ss, m_as;
    bit m_sa, m_aa;
    int col, row;
    bit dvp, vsp;
    int w[3][3][3];

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", nm, cyc, act, exp_v);
        end
    endtask

    task automatic model_defaults();
        int g[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        m_sc = g; m_ac = g;
        m_ss = 4; m_as = 4; m_sa = 0; m_aa = 0;
        col = 0; row = 0; dvp = 0; vsp = 0;
    endtask

    task automatic tick();
        int t, s, v;
        bit comp, rise;
        exp_t x;
        wr_t wr;
        t = cyc;
        if (!cfg_we && cfgq.size() > 0) begin
            wr = cfgq.pop_front();
            cfg_we = 1; cfg_addr = 4'(wr.a); cfg_wdata = 8'(wr.d);
        end
        hsr[t] = hs_i;
        vsr[t] = vs_i;
        if (rst) begin
            model_defaults();
            last_rst = t;
            while (q.size() > 0 && q[$].cyc > t) void'(q.pop_back());
            for (int c = t + 1; c <= t + 5; c++)
                if (expdv.exists(c) != 0) expdv.delete(c);
        end else begin
            comp = dv_i && col == 2 && row == 2;
            rise = vs_i && !vsp;
            if (rise) begin m_ac = m_sc; m_as = m_ss; m_aa = m_sa; end
            if (cfg_we) begin
                if (cfg_addr < 9) begin
                    v = cfg_wdata & 31;
                    if (v >= 16) v -= 32;
                    m_sc[cfg_addr] = v;
                end else if (cfg_addr == 9) m_ss = cfg_wdata % 16;
                else if (cfg_addr == 10) m_sa = cfg_wdata[0];
            end
            if (dv_i) begin
                for (int c = 0; c < 3; c++)
                    for (int r = 0; r < 3; r++) begin
                        w[c][2][r] = w[c][1][r];
                        w[c][1][r] = w[c][0][r];
                        w[c][0][r] = int'(vect_in[c][r]);
                    end
            end
            if (comp) begin
                x.cyc = t + 4;
                for (int c = 0; c < 3; c++) begin
                    s = 0;
                    for (int k = 0; k < 9; k++) s += m_ac[k] * w[c][k % 3][k / 3];
                    v = s >>> m_as;
                    if (v < 0) v = m_aa ? -v : 0;
                    if (v > 255) v = 255;
                    x.p[c] = v;
                end
                q.push_back(x);
                expdv[t + 4] = 1;
            end
            if (dv_i) begin
                if (col < 2) col++;
            end else if (dvp) col = 0;
            if (rise) row = 0;
            else if (!dv_i && dvp && row < 2) row++;
            dvp = dv_i;
            vsp = vs_i;
        end
        @(posedge clk);
        #1;
        if (rst) started = 1;
        cfg_we = 0;
    endtask

    // Monitor: compare every cycle against the scoreboard.
    always @(negedge clk) begin : mon
        bit e, le;
        int hx, vx;
        exp_t x;
        if (started) begin
            e = expdv.exists(cyc) != 0;
            le = (last_rst != cyc - 1) && (expdv.exists(cyc - 1) != 0) && !e;
            hx = (cyc - 4 > last_rst) ? int'(hsr[cyc - 4]) : 0;
            vx = (cyc - 4 > last_rst) ? int'(vsr[cyc - 4]) : 0;
            if (last_rst == cyc - 1) hold = '{0, 0, 0};
            chk("dv_o", int'(dv_o), int'(e));
            chk("line_end_o", int'(line_end_o), int'(le));
            chk("hs_o", int'(hs_o), hx);
            chk("vs_o", int'(vs_o), vx);
            if (dv_o) begin
                if (q.size() == 0) chk("unexpected_out", q.size(), 1);
                else begin
                    x = q.pop_front();
                    chk("out_cycle", cyc, x.cyc);
                    for (int c = 0; c < 3; c++) chk("pix", int'(pix_o[c]), x.p[c]);
                    hold = x.p;
                end
            end else begin
                for (int c = 0; c < 3; c++) chk("pix_hold", int'(pix_o[c]), hold[c]);
            end
        end
    end

    function automatic int gen(input int kind, input int c, input int y, input int x);
        case (kind)
            0: return 100;
            2: return (y == 3 && x == 5) ? 255 : 0;
            3: return (y == 3 && x == 5) ? 0 : 50;
            4: return (c == 0) ? ((x < 6) ? 0 : 200) : 77;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic kernel(input int k[9], input int sh, input int ab, input bit mid);
        wr_t wr;
        for (int i = 0; i < 11; i++) begin
            wr.a = i;
            wr.d = (i < 9) ? (k[i] & 255) : ((i == 9) ? sh : ab);
            if (mid) midq.push_back(wr);
            else cfgq.push_back(wr);
        end
    endtask

    task automatic frame(input int kind, input int nl, input int np,
                         input bit gaps, input int wr_line, input int rst_line,
                         input bit vs_wr, input int vs_a, input int vs_d);
        int yy;
        for (int c = 0; c < 3; c++)
            for (int y = 0; y < nl; y++)
                for (int x = 0; x < np; x++) img[c][y][x] = gen(kind, c, y, x);
        dv_i = 0; hs_i = 0; vs_i = 0;
        while (cfgq.size() > 0) tick();
        repeat (2) tick();
        vs_i = 1;
        if (vs_wr) begin
            cfg_we = 1; cfg_addr = 4'(vs_a); cfg_wdata = 8'(vs_d);
        end
        tick();
        tick();
        vs_i = 0;
        repeat (3) tick();
        for (int y = 0; y < nl; y++) begin
            if (y == wr_line)
                while (midq.size() > 0) cfgq.push_back(midq.pop_front());
            for (int x = 0; x < np; x++) begin
                if (y == rst_line && x == 5) begin
                    rst = 1; dv_i = 0; tick(); rst = 0;
                end
                dv_i = 1;
                for (int c = 0; c < 3; c++)
                    for (int r = 0; r < 3; r++) begin
                        yy = y - r;
                        vect_in[c][r] = (yy < 0) ? 8'd0 : 8'(img[c][yy][x]);
                    end
                tick();
                if (gaps && x % 3 == 2 && x != np - 1) begin
                    dv_i = 0; tick();
                end
            end
            dv_i = 0; tick();
            hs_i = 1; tick(); tick();
            hs_i = 0; tick(); tick();
        end
    endtask

    initial begin
        model_defaults();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        repeat (4) tick();
        frame(0, 8, 16, 0, -1, -1, 0, 0, 0);
        frame(1, 6, 12, 0, -1, -1, 0, 0, 0);
        kernel('{0, -1, 0, -1, 5, -1, 0, -1, 0}, 0, 0, 0);
        frame(2, 7, 12, 0, -1, -1, 0, 0, 0);
        frame(3, 7, 12, 0, -1, -1, 0, 0, 0);
        kernel('{0, -1, 0, -1, 5, -1, 0, -1, 0}, 0, 1, 0);
        frame(3, 7, 12, 0, -1, -1, 0, 0, 0);
        kernel('{-1, 0, 1, -2, 0, 2, -1, 0, 1}, 2, 1, 0);
        frame(4, 6, 14, 0, -1, -1, 0, 0, 0);
        frame(4, 6, 14, 0, -1, -1, 0, 0, 0);
        kernel('{1, 2, 1, 2, 4, 2, 1, 2, 1}, 4, 0, 0);
        frame(1, 6, 12, 0, -1, -1, 0, 0, 0);
        kernel('{1, 1, 1, 1, 1, 1, 1, 1, 1}, 3, 0, 1);
        frame(1, 6, 12, 0, 2, -1, 0, 0, 0);
        frame(1, 6, 12, 0, -1, -1, 1, 9, 0);
        frame(1, 6, 12, 0, -1, -1, 0, 0, 0);
        kernel('{1, 2, 1, 2, 4, 2, 1, 2, 1}, 4, 0, 0);
        frame(1, 6, 16, 1, -1, -1, 0, 0, 0);
        kernel('{0, -1, 0, -1, 5, -1, 0, -1, 0}, 1, 1, 0);
        frame(1, 6, 12, 0, -1, -1, 0, 0, 0);
        frame(1, 8, 14, 0, -1, 3, 0, 0, 0);
        frame(1, 6, 12, 0, -1, -1, 0, 0, 0);
        dv_i = 0;
        repeat (10) tick();
        chk("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
